game_turn_scheduler: RTL and testbench
======================================

// Module: game_turn_scheduler
// PURPOSE
//  Two-player turn scheduler for the Small_Game action FSM. Grants the single FSM to one player
//  per turn, forwards only that player's buttons, tracks positions and hit points, resolves
//  attacks and declares the winner. Sits between the board push-buttons and the action FSM.
// PARAMETERS
//  TURN_CYCLES  8  cycles per turn before a forced swap (>=2)
//  POS_MAX      7  highest board cell; positions range 0..POS_MAX (3-bit)
//  P0_START     1  reset position, player 0
//  P1_START     6  reset position, player 1
//  HP_INIT      3  reset hit points per player (2-bit)
//  ATK_WDOG     4  cycles ATK waits for the FSM Attack_active state (4) before giving up
// PORTS
//  clk            in   1  system clock, rising edge
//  reset          in   1  asynchronous, active-high; forces every register to its reset value
//  new_game       in   1  synchronous re-init to reset values (lower priority than reset)
//  p0_left/p0_right/p0_attack  in 1 each  player 0 buttons, synchronous, level
//  p1_left/p1_right/p1_attack  in 1 each  player 1 buttons
//  fsm_state      in   3  action FSM state (0 idle, 1 left, 2 right, 3 atk_start, 4 atk_active)
//  fsm_move_flag  in   1  action FSM move_flag
//  fsm_left/fsm_right/fsm_attack  out 1 each  gated buttons to the action FSM (combinational)
//  ctrl_state     out  2  0 TURN, 1 ATK, 2 SWAP, 3 OVER
//  active_player  out  1  player owning the FSM
//  turn_timer     out  4  cycles left in the turn
//  p0_pos, p1_pos out  3  board positions
//  p0_hp, p1_hp   out  2  hit points
//  game_over      out  1  high in OVER
//  winner         out  1  valid while game_over
// BEHAVIOUR
//  Reset/new_game: ctrl=TURN, active=0, timer=TURN_CYCLES-1, pos=P0_START/P1_START,
//   hp=HP_INIT, game_over=0, winner=0, ATK watchdog=0.
//  fsm_* = active player's buttons in TURN only; all 0 in ATK, SWAP and OVER.
//   The inactive player's buttons are always ignored.
//  TURN: if the forwarded attack is 1 -> ATK. Else if timer==0 -> SWAP. Else timer-1.
//   Attack wins over timer expiry in the same cycle.
//  ATK: holds the timer. Watchdog counts from 0. On the cycle fsm_state==4:
//   - If |p0_pos-p1_pos|==1, the opponent's hp drops by 1 (saturates at 0).
//   - If the new hp is 0 -> OVER, winner=active. Otherwise -> SWAP.
//   If the watchdog reaches ATK_WDOG-1 without state 4 -> SWAP, no hit.
//   Nominal timing: attack in TURN at cycle t; ATK at t+1 and t+2 (resolve at t+2);
//   SWAP at t+3; other player's TURN at t+4.
//  SWAP: lasts exactly one cycle. active toggles, timer reloads to TURN_CYCLES-1 -> TURN.
//  Movement (any state except OVER) applies to the current active player while fsm_move_flag=1:
//   - fsm_state==1: pos-1, saturating at 0.
//   - fsm_state==2: pos+1, saturating at POS_MAX.
//   - A move into the opponent's cell is blocked; pos holds.
//   Because of the FSM's one-cycle lag, a move requested on the last TURN cycle is applied
//   during SWAP, to the same player, before the toggle.
//  Left and right together are forwarded as-is; the FSM gives left priority.
//  OVER: all registers held, game_over=1. Exits only via reset or new_game.
//  Reset asserted mid-turn or mid-attack clears immediately (async); there is no partial resolve.
// TESTING
//  - Reset, then hold p1_attack=1 for 3 cycles -> fsm_attack stays 0, ctrl stays TURN, active=0.
//  - No input from P0 -> SWAP at cycle TURN_CYCLES, then active=1 and turn_timer=7.
//  - P0 right x4 (pos 1->5), P0 attack -> p1_hp 3->2 at t+2, SWAP at t+3, P1 TURN at t+4.
//  - P0 at 5, P1 at 6, P0 right -> p0_pos stays 5 (blocked). P0 left at 0 -> stays 0.
//  - Three adjacent hits on P1 -> p1_hp=0, ctrl=OVER, game_over=1, winner=0;
//    buttons ignored afterwards; new_game restores all reset values.
//  - Attack and timer==0 in the same cycle -> ATK. fsm_state held at 0 -> SWAP after 4 cycles,
//    hp unchanged.

Source files
------------

// File: rtl/game_turn_scheduler_if.sv
// Link between the turn scheduler and the Small_Game action FSM: gated buttons out,
// FSM state and move flag back.
interface game_turn_scheduler_if;
    logic [2:0] fsm_state;
    logic       fsm_move_flag;
    logic       fsm_left;
    logic       fsm_right;
    logic       fsm_attack;

    modport master (
        input  fsm_state,
        input  fsm_move_flag,
        output fsm_left,
        output fsm_right,
        output fsm_attack
    );

    modport slave (
        output fsm_state,
        output fsm_move_flag,
        input  fsm_left,
        input  fsm_right,
        input  fsm_attack
    );
endinterface

// File: rtl/game_turn_scheduler.sv
// Two-player turn scheduler: grants the action FSM to one player per turn, tracks positions
// and hit points, resolves attacks and declares the winner.
module game_turn_scheduler #(
    parameter int unsigned TURN_CYCLES = 8,
    parameter int unsigned POS_MAX     = 7,
    parameter int unsigned P0_START    = 1,
    parameter int unsigned P1_START    = 6,
    parameter int unsigned HP_INIT     = 3,
    parameter int unsigned ATK_WDOG    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_game,
    input  logic                  p0_left,
    input  logic                  p0_right,
    input  logic                  p0_attack,
    input  logic                  p1_left,
    input  logic                  p1_right,
    input  logic                  p1_attack,
    game_turn_scheduler_if.master fsm_bus,
    output logic [1:0]            ctrl_state,
    output logic                  active_player,
    output logic [3:0]            turn_timer,
    output logic [2:0]            p0_pos,
    output logic [2:0]            p1_pos,
    output logic [1:0]            p0_hp,
    output logic [1:0]            p1_hp,
    output logic                  game_over,
    output logic                  winner
);

    localparam logic [1:0] StTurn = 2'd0;
    localparam logic [1:0] StAtk  = 2'd1;
    localparam logic [1:0] StSwap = 2'd2;
    localparam logic [1:0] StOver = 2'd3;

    localparam logic [2:0] FsmLeft      = 3'd1;
    localparam logic [2:0] FsmRight     = 3'd2;
    localparam logic [2:0] FsmAtkActive = 3'd4;

    localparam logic [3:0] TimerReload = 4'(TURN_CYCLES - 1);
    localparam logic [3:0] WdogLast    = 4'(ATK_WDOG - 1);
    localparam logic [2:0] PosMax      = 3'(POS_MAX);
    localparam logic [2:0] P0Start     = 3'(P0_START);
    localparam logic [2:0] P1Start     = 3'(P1_START);
    localparam logic [1:0] HpInit      = 2'(HP_INIT);

    logic [1:0] ctrl_q, ctrl_d;
    logic       active_q, active_d;
    logic [3:0] timer_q, timer_d;
    logic [3:0] wdog_q, wdog_d;
    logic [2:0] p0_pos_q, p0_pos_d, p1_pos_q, p1_pos_d;
    logic [1:0] p0_hp_q, p0_hp_d, p1_hp_q, p1_hp_d;
    logic       winner_q, winner_d;

    logic       act_left, act_right, act_attack, in_turn;
    logic [2:0] my_pos, opp_pos, move_tgt, pos_gap;
    logic [1:0] opp_hp, hit_hp;

    always_comb begin
        act_left   = active_q ? p1_left   : p0_left;
        act_right  = active_q ? p1_right  : p0_right;
        act_attack = active_q ? p1_attack : p0_attack;
        in_turn    = (ctrl_q == StTurn);
        fsm_bus.fsm_left   = in_turn & act_left;
        fsm_bus.fsm_right  = in_turn & act_right;
        fsm_bus.fsm_attack = in_turn & act_attack;
    end

    // Move target for the active player; saturating at the board edges.
    always_comb begin
        my_pos   = active_q ? p1_pos_q : p0_pos_q;
        opp_pos  = active_q ? p0_pos_q : p1_pos_q;
        move_tgt = my_pos;
        if (fsm_bus.fsm_state == FsmLeft && my_pos != 3'd0) begin
            move_tgt = my_pos - 3'd1;
        end else if (fsm_bus.fsm_state == FsmRight && my_pos != PosMax) begin
            move_tgt = my_pos + 3'd1;
        end
        pos_gap = (p0_pos_q > p1_pos_q) ? p0_pos_q - p1_pos_q : p1_pos_q - p0_pos_q;
        opp_hp  = active_q ? p0_hp_q : p1_hp_q;
        hit_hp  = (pos_gap == 3'd1 && opp_hp != 2'd0) ? opp_hp - 2'd1 : opp_hp;
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        active_d = active_q;
        timer_d  = timer_q;
        wdog_d   = wdog_q;
        p0_pos_d = p0_pos_q;
        p1_pos_d = p1_pos_q;
        p0_hp_d  = p0_hp_q;
        p1_hp_d  = p1_hp_q;
        winner_d = winner_q;
        if (new_game) begin
            ctrl_d   = StTurn;
            active_d = 1'b0;
            timer_d  = TimerReload;
            wdog_d   = '0;
            p0_pos_d = P0Start;
            p1_pos_d = P1Start;
            p0_hp_d  = HpInit;
            p1_hp_d  = HpInit;
            winner_d = 1'b0;
        end else begin
            // A move landing in SWAP still belongs to the outgoing player (active not yet toggled).
            if (ctrl_q != StOver && fsm_bus.fsm_move_flag && move_tgt != opp_pos) begin
                if (active_q) p1_pos_d = move_tgt;
                else          p0_pos_d = move_tgt;
            end
            case (ctrl_q)
                StTurn: begin
                    wdog_d = '0;
                    if (act_attack)           ctrl_d  = StAtk;
                    else if (timer_q == 4'd0) ctrl_d  = StSwap;
                    else                      timer_d = timer_q - 4'd1;
                end
                StAtk: begin
                    if (fsm_bus.fsm_state == FsmAtkActive) begin
                        if (active_q) p0_hp_d = hit_hp;
                        else          p1_hp_d = hit_hp;
                        if (hit_hp == 2'd0) begin
                            ctrl_d   = StOver;
                            winner_d = active_q;
                        end else begin
                            ctrl_d = StSwap;
                        end
                    end else if (wdog_q == WdogLast) begin
                        ctrl_d = StSwap;
                    end else begin
                        wdog_d = wdog_q + 4'd1;
                    end
                end
                StSwap: begin
                    active_d = ~active_q;
                    timer_d  = TimerReload;
                    ctrl_d   = StTurn;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q   <= StTurn;
            active_q <= 1'b0;
            timer_q  <= TimerReload;
            wdog_q   <= '0;
            p0_pos_q <= P0Start;
            p1_pos_q <= P1Start;
            p0_hp_q  <= HpInit;
            p1_hp_q  <= HpInit;
            winner_q <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            active_q <= active_d;
            timer_q  <= timer_d;
            wdog_q   <= wdog_d;
            p0_pos_q <= p0_pos_d;
            p1_pos_q <= p1_pos_d;
            p0_hp_q  <= p0_hp_d;
            p1_hp_q  <= p1_hp_d;
            winner_q <= winner_d;
        end
    end

    assign ctrl_state    = ctrl_q;
    assign active_player = active_q;
    assign turn_timer    = timer_q;
    assign p0_pos        = p0_pos_q;
    assign p1_pos        = p1_pos_q;
    assign p0_hp         = p0_hp_q;
    assign p1_hp         = p1_hp_q;
    assign game_over     = (ctrl_q == StOver);
    assign winner        = winner_q;

endmodule

// File: tb/tb_game_turn_scheduler.sv
// Directed bench for game_turn_scheduler; the bench plays the role of the action FSM.
module tb_game_turn_scheduler;

    localparam logic [1:0] TURN = 2'd0;
    localparam logic [1:0] ATK  = 2'd1;
    localparam logic [1:0] SWAP = 2'd2;
    localparam logic [1:0] OVER = 2'd3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       new_game = 1'b0;
    logic       p0_left = 1'b0, p0_right = 1'b0, p0_attack = 1'b0;
    logic       p1_left = 1'b0, p1_right = 1'b0, p1_attack = 1'b0;
    logic [1:0] ctrl_state;
    logic       active_player;
    logic [3:0] turn_timer;
    logic [2:0] p0_pos, p1_pos;
    logic [1:0] p0_hp, p1_hp;
    logic       game_over, winner;

    int checks = 0;
    int errors = 0;

    game_turn_scheduler_if bus ();

    game_turn_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .new_game     (new_game),
        .p0_left      (p0_left),
        .p0_right     (p0_right),
        .p0_attack    (p0_attack),
        .p1_left      (p1_left),
        .p1_right     (p1_right),
        .p1_attack    (p1_attack),
        .fsm_bus      (bus),
        .ctrl_state   (ctrl_state),
        .active_player(active_player),
        .turn_timer   (turn_timer),
        .p0_pos       (p0_pos),
        .p1_pos       (p1_pos),
        .p0_hp        (p0_hp),
        .p1_hp        (p1_hp),
        .game_over    (game_over),
        .winner       (winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctrl"}, ctrl_state, TURN);
        check({tag, "_active"}, active_player, 0);
        check({tag, "_timer"}, turn_timer, 7);
        check({tag, "_p0pos"}, p0_pos, 1);
        check({tag, "_p1pos"}, p1_pos, 6);
        check({tag, "_p0hp"}, p0_hp, 3);
        check({tag, "_p1hp"}, p1_hp, 3);
        check({tag, "_over"}, game_over, 0);
        check({tag, "_winner"}, winner, 0);
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    // Attack press, then FSM goes atk_start, atk_active; returns one cycle after resolve.
    task automatic attack_cycle(input logic player);
        if (player) p1_attack = 1'b1;
        else        p0_attack = 1'b1;
        #1;
        check("atk_fwd", bus.fsm_attack, 1);
        tick();
        check("atk_enter", ctrl_state, ATK);
        p0_attack = 1'b0;
        p1_attack = 1'b0;
        bus.fsm_state = 3'd3;
        #1;
        check("atk_gated", bus.fsm_attack, 0);
        tick();
        check("atk_hold", ctrl_state, ATK);
        bus.fsm_state = 3'd4;
        tick();
        bus.fsm_state = 3'd0;
    endtask

    task automatic wait_turn(input logic player);
        int n = 0;
        while (!(ctrl_state == TURN && active_player == player) && n < 40) begin
            tick();
            n++;
        end
        check("wait_turn", {ctrl_state, active_player}, {TURN, player});
    endtask

    initial begin
        bus.fsm_state     = 3'd0;
        bus.fsm_move_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst_held");
        reset = 1'b0;
        #1;
        check_reset_vals("rst_rel");

        // Inactive player's attack is never forwarded.
        p1_attack = 1'b1;
        #1;
        check("p1atk_fwd", bus.fsm_attack, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("p1atk_ctrl", ctrl_state, TURN);
            check("p1atk_active", active_player, 0);
            check("p1atk_fsm", bus.fsm_attack, 0);
        end
        check("p1atk_timer", turn_timer, 4);
        p1_attack = 1'b0;

        // Timeout swap with no input.
        pulse_new_game();
        check("ng_timer", turn_timer, 7);
        repeat (7) tick();
        check("to_timer0", turn_timer, 0);
        check("to_turn", ctrl_state, TURN);
        tick();
        check("to_swap", ctrl_state, SWAP);
        check("to_swap_act", active_player, 0);
        tick();
        check("to_turn1", ctrl_state, TURN);
        check("to_active1", active_player, 1);
        check("to_reload", turn_timer, 7);
        p1_left  = 1'b1;
        p0_right = 1'b1;
        #1;
        check("p1_left_fwd", bus.fsm_left, 1);
        check("p0_right_blk", bus.fsm_right, 0);
        p1_left  = 1'b0;
        p0_right = 1'b0;

        // P0 walks right 1->5, blocked at 5, then hits P1.
        pulse_new_game();
        p0_right = 1'b1;
        #1;
        check("p0_right_fwd", bus.fsm_right, 1);
        bus.fsm_state     = 3'd2;
        bus.fsm_move_flag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("walk_pos", p0_pos, 2 + i);
        end
        tick();
        check("blocked_pos", p0_pos, 5);
        check("blocked_p1", p1_pos, 6);
        p0_right          = 1'b0;
        bus.fsm_state     = 3'd0;
        bus.fsm_move_flag = 1'b0;
        check("pre_atk_timer", turn_timer, 2);
        attack_cycle(1'b0);
        check("hit_swap", ctrl_state, SWAP);
        check("hit_p1hp", p1_hp, 2);
        check("hit_p0hp", p0_hp, 3);
        check("hit_timer_held", turn_timer, 2);
        tick();
        check("hit_turn", ctrl_state, TURN);
        check("hit_active", active_player, 1);
        check("hit_reload", turn_timer, 7);

        // Left saturation at cell 0.
        pulse_new_game();
        bus.fsm_state     = 3'd1;
        bus.fsm_move_flag = 1'b1;
        tick();
        check("left_pos0", p0_pos, 0);
        tick();
        check("left_sat", p0_pos, 0);
        bus.fsm_state     = 3'd0;
        bus.fsm_move_flag = 1'b0;

        // Three hits on P1 end the game.
        pulse_new_game();
        bus.fsm_state     = 3'd2;
        bus.fsm_move_flag = 1'b1;
        repeat (4) tick();
        bus.fsm_state     = 3'd0;
        bus.fsm_move_flag = 1'b0;
        check("ko_setup_pos", p0_pos, 5);
        attack_cycle(1'b0);
        check("ko_hp2", p1_hp, 2);
        wait_turn(1'b0);
        attack_cycle(1'b0);
        check("ko_hp1", p1_hp, 1);
        check("ko_ctrl1", ctrl_state, SWAP);
        wait_turn(1'b0);
        attack_cycle(1'b0);
        check("ko_hp0", p1_hp, 0);
        check("ko_over", ctrl_state, OVER);
        check("ko_game_over", game_over, 1);
        check("ko_winner", winner, 0);
        p0_right  = 1'b1;
        p0_attack = 1'b1;
        #1;
        check("over_right", bus.fsm_right, 0);
        check("over_attack", bus.fsm_attack, 0);
        bus.fsm_state     = 3'd1;
        bus.fsm_move_flag = 1'b1;
        tick();
        tick();
        check("over_pos", p0_pos, 5);
        check("over_hold", ctrl_state, OVER);
        check("over_hp", p1_hp, 0);
        p0_right          = 1'b0;
        p0_attack         = 1'b0;
        bus.fsm_state     = 3'd0;
        bus.fsm_move_flag = 1'b0;
        pulse_new_game();
        check_reset_vals("newgame");

        // Attack on timer==0, FSM never reaches atk_active: watchdog swap, no hit.
        repeat (7) tick();
        check("wd_timer0", turn_timer, 0);
        p0_attack = 1'b1;
        tick();
        p0_attack = 1'b0;
        check("wd_atk", ctrl_state, ATK);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wd_wait", ctrl_state, ATK);
        end
        tick();
        check("wd_swap", ctrl_state, SWAP);
        check("wd_p0hp", p0_hp, 3);
        check("wd_p1hp", p1_hp, 3);
        tick();
        check("wd_turn", ctrl_state, TURN);
        check("wd_active", active_player, 1);

        // Async reset mid-attack clears before the next edge.
        p1_attack = 1'b1;
        tick();
        p1_attack = 1'b0;
        check("ar_atk", ctrl_state, ATK);
        #2;
        reset = 1'b1;
        #1;
        check("ar_ctrl", ctrl_state, TURN);
        check("ar_active", active_player, 0);
        check("ar_timer", turn_timer, 7);
        reset = 1'b0;
        tick();
        check("ar_count", turn_timer, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
